// File: rtl/apb4_i2s_ctrl.sv
// rtl/apb4_i2s_ctrl.sv - APB4 I2S master transmitter/receiver with TX/RX sample FIFOs
// Register bank, SCK/WS generation, serialiser and deserialiser share clk_i.

module apb4_i2s_fifo #(
   parameter int DEPTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr,
   input  logic             push,
   input  logic [31:0]      wdata,
   input  logic             pop,
   output logic [31:0]      rdata,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);
   localparam int AW = CNT_W - 1;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop & ~empty;
   // a pop in the same cycle frees the slot a full-FIFO push needs
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk_i) begin
      if (rst_i || clr) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !clr) mem[wr_ptr] <= wdata;
   end
endmodule

module apb4_i2s_ctrl #(
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 5
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] paddr_i,
   input  logic        psel_i,
   input  logic        penable_i,
   input  logic        pwrite_i,
   input  logic [31:0] pwdata_i,
   output logic [31:0] prdata_o,
   output logic        pready_o,
   output logic        pslverr_o,
   output logic        sck_o,
   output logic        ws_o,
   output logic        sd_o,
   input  logic        sd_i,
   output logic        irq_o
);
   localparam logic [2:0] A_CTRL = 3'd0;
   localparam logic [2:0] A_DIV  = 3'd1;
   localparam logic [2:0] A_TXR  = 3'd2;
   localparam logic [2:0] A_RXR  = 3'd3;
   localparam logic [2:0] A_STAT = 3'd4;

   logic        en_q, txen_q, rxen_q, fmt_q, txie_q, rxie_q, txudr_q, rxovr_q;
   logic [1:0]  dl_q;
   logic [15:0] div_q, cnt_q;
   logic        sck_q, started_q, sd_q;
   logic [5:0]  idx_q;
   logic [31:0] tx_sample_q, rx_shift_q;

   logic             acc, wr;
   logic [2:0]       ra;
   logic             tx_clr, tx_push, tx_pop, tx_full, tx_empty;
   logic             rx_clr, rx_push, rx_pop, rx_full, rx_empty;
   logic [31:0]      tx_head, rx_head, rx_word;
   logic [CNT_W-1:0] tx_cnt, rx_cnt;

   logic        tick, rise, fall, tx_load, rx_act, rx_done, sd_nxt;
   logic [5:0]  idx_nxt, datlen, bpos;
   logic [4:0]  pf, pc;
   logic [31:0] cur_sample, rx_shift_nxt;
   logic        unused_bits;

   assign acc     = psel_i & penable_i;
   assign wr      = acc & pwrite_i;
   assign ra      = paddr_i[4:2];
   assign tx_clr  = wr && (ra == A_CTRL) && pwdata_i[12];
   assign rx_clr  = wr && (ra == A_CTRL) && pwdata_i[13];
   assign tx_push = wr && (ra == A_TXR);
   assign rx_pop  = acc && !pwrite_i && (ra == A_RXR);

   assign tick    = en_q && (cnt_q == div_q);
   assign rise    = tick && !sck_q;
   assign fall    = tick && sck_q;
   assign idx_nxt = idx_q + 6'd1;
   assign pf      = idx_nxt[4:0];
   assign pc      = idx_q[4:0];
   assign datlen  = {({1'b0, dl_q} + 3'd1), 3'b000};

   // falling edge: advance idx, reload at slot start, drive the bit for the new position
   assign tx_load    = fall && txen_q && (pf == 5'd0);
   assign tx_pop     = tx_load;
   assign cur_sample = tx_load ? (tx_empty ? 32'd0 : tx_head) : tx_sample_q;
   assign bpos       = datlen - 6'd1 - {1'b0, pf};
   assign sd_nxt     = txen_q && ({1'b0, pf} < datlen) && cur_sample[bpos[4:0]];

   assign rx_act       = rise && started_q && rxen_q && ({1'b0, pc} < datlen);
   assign rx_done      = rx_act && ({1'b0, pc} == (datlen - 6'd1));
   assign rx_shift_nxt = {rx_shift_q[30:0], sd_i};
   assign rx_word      = rx_shift_nxt & (32'hFFFF_FFFF >> (6'd32 - datlen));
   assign rx_push      = rx_done;

   apb4_i2s_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_tx_fifo (
      .clk_i(clk_i), .rst_i(rst_i), .clr(tx_clr), .push(tx_push), .wdata(pwdata_i),
      .pop(tx_pop), .rdata(tx_head), .count(tx_cnt), .full(tx_full), .empty(tx_empty)
   );

   apb4_i2s_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_rx_fifo (
      .clk_i(clk_i), .rst_i(rst_i), .clr(rx_clr), .push(rx_push), .wdata(rx_word),
      .pop(rx_pop), .rdata(rx_head), .count(rx_cnt), .full(rx_full), .empty(rx_empty)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         en_q <= 1'b0; txen_q <= 1'b0; rxen_q <= 1'b0; fmt_q <= 1'b0;
         txie_q <= 1'b0; rxie_q <= 1'b0; dl_q <= 2'd0; div_q <= 16'd0;
         txudr_q <= 1'b0; rxovr_q <= 1'b0;
      end else begin
         if (wr && ra == A_CTRL) begin
            en_q   <= pwdata_i[0];
            txen_q <= pwdata_i[1];
            rxen_q <= pwdata_i[2];
            dl_q   <= pwdata_i[5:4];
            fmt_q  <= pwdata_i[6];
            txie_q <= pwdata_i[8];
            rxie_q <= pwdata_i[9];
         end
         if (wr && ra == A_DIV) div_q <= pwdata_i[15:0];
         if (wr && ra == A_STAT && pwdata_i[4]) txudr_q <= 1'b0;
         if (wr && ra == A_STAT && pwdata_i[5]) rxovr_q <= 1'b0;
         if (tx_load && tx_empty) txudr_q <= 1'b1;
         if (rx_done && rx_full && !rx_pop) rxovr_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || !en_q) begin
         cnt_q     <= 16'd0;
         sck_q     <= 1'b0;
         idx_q     <= 6'd63;
         started_q <= 1'b0;
         sd_q      <= 1'b0;
      end else begin
         if (tick) begin
            cnt_q <= 16'd0;
            sck_q <= ~sck_q;
         end else begin
            cnt_q <= cnt_q + 16'd1;
         end
         if (fall) begin
            idx_q     <= idx_nxt;
            started_q <= 1'b1;
            sd_q      <= sd_nxt;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (tx_load) tx_sample_q <= cur_sample;
      if (rx_act)  rx_shift_q  <= rx_shift_nxt;
   end

   // outputs are gated so that clearing EN silences the bus in the same cycle
   assign sck_o     = sck_q & en_q;
   assign sd_o      = sd_q & en_q & txen_q;
   assign ws_o      = en_q & (fmt_q ? idx_q[5] : idx_nxt[5]);
   assign irq_o     = (txie_q & tx_empty) | (rxie_q & ~rx_empty);
   assign pready_o  = 1'b1;
   assign pslverr_o = acc & (ra > 3'd5);

   always_comb begin
      prdata_o = 32'd0;
      case (ra)
         A_CTRL: prdata_o = {22'd0, rxie_q, txie_q, 1'b0, fmt_q, dl_q, 1'b0, rxen_q, txen_q, en_q};
         A_DIV:  prdata_o = {16'd0, div_q};
         A_RXR:  prdata_o = rx_empty ? 32'd0 : rx_head;
         A_STAT: prdata_o = {11'd0, rx_cnt, 3'd0, tx_cnt, 2'd0, rxovr_q, txudr_q,
                             rx_empty, rx_full, tx_empty, tx_full};
         default: prdata_o = 32'd0;
      endcase
   end

   assign unused_bits = ^{paddr_i[31:5], paddr_i[1:0], rx_shift_q[31], bpos[5]};
endmodule

// File: tb/tb_apb4_i2s_ctrl.sv
// tb/tb_apb4_i2s_ctrl.sv - directed self-checking bench for apb4_i2s_ctrl
// Serial timing is checked against an idx model rebuilt from observed SCK falling edges.

module tb_apb4_i2s_ctrl;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [31:0] paddr_i = '0;
   logic        psel_i = 1'b0;
   logic        penable_i = 1'b0;
   logic        pwrite_i = 1'b0;
   logic [31:0] pwdata_i = '0;
   logic [31:0] prdata_o;
   logic        pready_o, pslverr_o, sck_o, ws_o, sd_o, irq_o;
   logic        sd_drv = 1'b0;
   logic        lb = 1'b0;
   logic        sd_in;

   int errors = 0;
   int checks = 0;

   logic [31:0] rdata;
   logic        rerr, rrdy;
   logic        prev;
   int          toggles, falls, ws_bad, ws_ones, sd_bad, sd_ones, idx;

   assign sd_in = lb ? sd_o : sd_drv;

   apb4_i2s_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i), .paddr_i(paddr_i), .psel_i(psel_i),
      .penable_i(penable_i), .pwrite_i(pwrite_i), .pwdata_i(pwdata_i),
      .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
      .sck_o(sck_o), .ws_o(ws_o), .sd_o(sd_o), .sd_i(sd_in), .irq_o(irq_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
      @(posedge clk_i); #1;
      psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = a; pwdata_i = d;
      @(posedge clk_i); #1;
      penable_i = 1'b1;
      @(posedge clk_i); #1;
      psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
   endtask

   task automatic apb_read(input logic [31:0] a);
      @(posedge clk_i); #1;
      psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = a;
      @(posedge clk_i); #1;
      penable_i = 1'b1;
      #1;
      rdata = prdata_o; rerr = pslverr_o; rrdy = pready_o;
      @(posedge clk_i); #1;
      psel_i = 1'b0; penable_i = 1'b0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;
   endtask

   initial begin
      // reset state
      do_reset();
      apb_read(32'h00); chk("rst_ctrl", rdata, 32'h0);
      chk("rst_pready", {31'd0, rrdy}, 32'd1);
      apb_read(32'h04); chk("rst_div", rdata, 32'h0);
      apb_read(32'h10); chk("rst_stat", rdata, 32'h0000000A);
      chk("rst_pins", {28'd0, sck_o, ws_o, sd_o, irq_o}, 32'h0);

      // register access
      apb_write(32'h04, 32'h0000_1234);
      apb_read(32'h04); chk("div_rb", rdata, 32'h0000_1234);
      apb_read(32'h18); chk("bad_err", {31'd0, rerr}, 32'd1);
      chk("bad_data", rdata, 32'h0);
      chk("bad_pready", {31'd0, rrdy}, 32'd1);
      apb_read(32'h08); chk("txr_reads0", rdata, 32'h0);
      apb_read(32'h14); chk("r14_err", {31'd0, rerr}, 32'd0);

      // loopback, DIV=0, 16-bit Philips
      do_reset();
      lb = 1'b1;
      apb_write(32'h08, 32'h0000_1234);
      apb_write(32'h08, 32'h0000_ABCD);
      apb_write(32'h00, 32'h0000_0017);
      prev = 1'b0; toggles = 0; falls = 0; ws_bad = 0; ws_ones = 0;
      for (int k = 0; k < 140; k++) begin
         @(negedge clk_i);
         if (k >= 1 && k <= 128 && sck_o !== prev) toggles++;
         if (prev && !sck_o) falls++;
         prev = sck_o;
         if (falls > 0) begin
            idx = (falls - 1) % 64;
            if (ws_o !== ((idx >= 31 && idx <= 62) ? 1'b1 : 1'b0)) ws_bad++;
            if (ws_o) ws_ones++;
         end
      end
      chk("lb_sck_toggles", toggles, 128);
      chk("lb_ws_bad", ws_bad, 0);
      chk("lb_ws_ones", ws_ones, 64);
      apb_read(32'h10); chk("lb_rxcnt", (rdata >> 16) & 32'h1F, 32'd2);
      apb_read(32'h0C); chk("lb_rx0", rdata, 32'h0000_1234);
      apb_read(32'h0C); chk("lb_rx1", rdata, 32'h0000_ABCD);
      lb = 1'b0;

      // TX underflow and TX interrupt
      do_reset();
      apb_write(32'h00, 32'h0000_0003);
      sd_ones = 0;
      for (int k = 0; k < 140; k++) begin
         @(negedge clk_i);
         if (sd_o) sd_ones++;
      end
      chk("udr_sd_quiet", sd_ones, 0);
      apb_read(32'h10); chk("udr_set", (rdata >> 4) & 32'h1, 32'd1);
      apb_write(32'h00, 32'h0000_0100);
      chk("udr_irq", {31'd0, irq_o}, 32'd1);
      chk("udr_sck_off", {31'd0, sck_o}, 32'd0);
      apb_write(32'h10, 32'h0000_0010);
      apb_read(32'h10); chk("udr_clr", rdata, 32'h0000_000A);

      // RX overflow with sd_i held high, 8-bit words
      do_reset();
      sd_drv = 1'b1;
      apb_write(32'h00, 32'h0000_0005);
      repeat (1100) @(negedge clk_i);
      apb_write(32'h00, 32'h0000_0000);
      apb_read(32'h10); chk("ovr_stat", rdata, 32'h0010_0026);
      apb_read(32'h0C); chk("ovr_word", rdata, 32'h0000_00FF);
      apb_read(32'h10); chk("ovr_stat_pop", rdata, 32'h000F_0022);
      apb_write(32'h00, 32'h0000_2000);
      apb_read(32'h10); chk("ovr_rxclr", rdata, 32'h0000_002A);
      apb_write(32'h10, 32'h0000_0020);
      apb_read(32'h10); chk("ovr_sticky_clr", rdata, 32'h0000_000A);
      sd_drv = 1'b0;

      // left-justified, 32-bit word
      do_reset();
      apb_write(32'h08, 32'h8000_0001);
      apb_write(32'h00, 32'h0000_0073);
      prev = 1'b0; falls = 0; ws_bad = 0; sd_bad = 0; sd_ones = 0;
      for (int k = 0; k < 140; k++) begin
         @(negedge clk_i);
         if (prev && !sck_o) falls++;
         prev = sck_o;
         if (falls > 0 && falls <= 64) begin
            idx = falls - 1;
            if (sd_o !== ((idx == 0 || idx == 31) ? 1'b1 : 1'b0)) sd_bad++;
            if (sd_o) sd_ones++;
            if (ws_o !== ((idx >= 32) ? 1'b1 : 1'b0)) ws_bad++;
         end
      end
      chk("lj_sd_bad", sd_bad, 0);
      chk("lj_sd_ones", sd_ones, 4);
      chk("lj_ws_bad", ws_bad, 0);
      chk("lj_falls", falls, 69);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
